// File: rtl/button_bank_debounce.sv
// button_bank_debounce: per-key synchroniser, debounce filter, press/release/long pulses.
// Define AUTO_REPEAT_EN to build the auto-repeat counter; otherwise key_repeat is tied low.
module button_bank_debounce #(
   parameter int N_KEYS          = 4,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LONG_CYCLES     = 20,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);
   localparam int DBW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HW  = $clog2(LONG_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {IDLE, HOLD, LONG} hold_state_e;

   if (N_KEYS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $error("button_bank_debounce: N_KEYS and cycle parameters must be >= 1");
   end

   logic [N_KEYS-1:0] s1_q, s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= key_raw_in ^ {N_KEYS{ACTIVE_LOW}};
         s2_q <= s1_q;
      end
   end

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      logic [DBW-1:0] db_cnt_q, db_cnt_d;
      logic           level_q, level_d;
      logic [HW-1:0]  hold_cnt_q;
      hold_state_e    state_q;
      logic           press_q, release_q, long_q;
      logic           rise, fall, long_hit;

      // The level only flips once the synced input has disagreed for DEBOUNCE_CYCLES cycles in a row.
      always_comb begin
         db_cnt_d = (s2_q[k] == level_q || db_cnt_q == DB_LAST) ? '0 : db_cnt_q + DBW'(1);
         level_d  = (s2_q[k] != level_q && db_cnt_q == DB_LAST) ? s2_q[k] : level_q;
      end

      assign rise     = level_d & ~level_q;
      assign fall     = level_q & ~level_d;
      assign long_hit = state_q == HOLD && hold_cnt_q == HOLD_LAST && !fall;

      always_ff @(posedge clk) begin
         if (reset) begin
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
         end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            long_q    <= long_hit;
            if (fall) begin
               state_q <= IDLE;
            end else if (rise) begin
               state_q    <= HOLD;
               hold_cnt_q <= '0;
            end else if (long_hit) begin
               state_q <= LONG;
            end else if (state_q == HOLD && hold_cnt_q != HOLD_LAST) begin
               hold_cnt_q <= hold_cnt_q + HW'(1);
            end
         end
      end

      assign key_level[k]   = level_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = release_q;
      assign key_long[k]    = long_q;

`ifdef AUTO_REPEAT_EN
      logic [RW-1:0] rep_cnt_q;
      logic          repeat_q, rep_hit;

      // Counter idles at zero outside LONG, so the first repeat lands REPEAT_CYCLES after key_long.
      assign rep_hit = state_q == LONG && rep_cnt_q == REP_LAST && !fall;

      always_ff @(posedge clk) begin
         if (reset) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
         end else begin
            repeat_q  <= rep_hit;
            rep_cnt_q <= (state_q != LONG || rep_hit) ? '0 : rep_cnt_q + RW'(1);
         end
      end

      assign key_repeat[k] = repeat_q;
`else
      assign key_repeat[k] = 1'b0;
`endif
   end
endmodule

// File: tb/tb_button_bank_debounce.sv
// tb_button_bank_debounce: vector table, corner sequences and a random run against a cycle-count model.
`timescale 1ns/1ps
module tb_button_bank_debounce;
   localparam int N = 4, D = 4, L = 20, R = 8;
`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct {
      logic         rst;
      logic [N-1:0] raw;
      logic [N-1:0] level;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] lng;
   } vec_t;

   logic         clk = 1'b0, reset = 1'b1;
   logic [N-1:0] key_raw_in = '0;
   logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;
   logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0, e_repeat = '0;
   int vectors = 0, errors = 0, cyc = 0;
   int m_s1[N], m_s2[N], m_lvl[N], m_run[N], m_age[N];

   button_bank_debounce #(.N_KEYS(N), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(D),
                          .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
      .clk(clk), .reset(reset), .key_raw_in(key_raw_in), .key_level(key_level),
      .key_press(key_press), .key_release(key_release), .key_long(key_long),
      .key_repeat(key_repeat));

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // Model: a key's age counts edges since its debounced press; long at age L, repeats every R after.
   task automatic model_step();
      for (int k = 0; k < N; k++) begin
         int nl;
         if (reset) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_run[k] = 0; m_age[k] = -1;
            e_level[k] = 0; e_press[k] = 0; e_release[k] = 0; e_long[k] = 0; e_repeat[k] = 0;
         end else begin
            nl = m_lvl[k];
            if (m_s2[k] != m_lvl[k]) begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  nl = m_s2[k];
                  m_run[k] = 0;
               end
            end else m_run[k] = 0;
            e_press[k]   = (nl == 1 && m_lvl[k] == 0);
            e_release[k] = (nl == 0 && m_lvl[k] == 1);
            e_long[k] = 0;
            e_repeat[k] = 0;
            if (e_press[k]) m_age[k] = 0;
            else if (e_release[k]) m_age[k] = -1;
            else if (m_age[k] >= 0) begin
               m_age[k]++;
               e_long[k]   = (m_age[k] == L);
               e_repeat[k] = AR && m_age[k] > L && (m_age[k] - L) % R == 0;
            end
            m_lvl[k] = nl;
            e_level[k] = (nl != 0);
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(key_raw_in[k]);
         end
      end
   endtask

   task automatic step(input logic rst, input logic [N-1:0] raw);
      reset = rst;
      key_raw_in = raw;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check("model_level", int'(key_level), int'(e_level));
      check("model_press", int'(key_press), int'(e_press));
      check("model_release", int'(key_release), int'(e_release));
      check("model_long", int'(key_long), int'(e_long));
      check("model_repeat", int'(key_repeat), int'(e_repeat));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   initial begin
      vec_t tbl[18];
      int np, pp, nl, lp, nr, rp, nrel, relp;
      logic [N-1:0] pv, lv, raw;
      int hold_left[N];
      logic [N-1:0] rnd_lvl;

      tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[3]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[5]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[6]  = '{1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
      tbl[7]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[10] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[11] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[12] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[13] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[14] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[15] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
      tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].rst, tbl[i].raw);
         check("tbl_level", int'(key_level), int'(tbl[i].level));
         check("tbl_press", int'(key_press), int'(tbl[i].press));
         check("tbl_release", int'(key_release), int'(tbl[i].rel));
         check("tbl_long", int'(key_long), int'(tbl[i].lng));
      end
      idle(4);

      // Key1 bounce: three 3-cycle pulses then steady; only the final edge may count.
      np = 0; pp = -1;
      for (int i = 0; i < 27; i++) begin
         raw = '0;
         raw[1] = (i < 3) || (i >= 6 && i < 9) || (i >= 12);
         step(1'b0, raw);
         if (key_press[1]) begin np++; pp = i; end
      end
      check("bounce_press_count", np, 1);
      check("bounce_press_pos", pp, 17);
      idle(10);

      // Key2 held: long at press+20, repeats at press+28 and +36 when built in.
      nl = 0; lp = -1; nr = 0; rp = -1;
      for (int i = 0; i < 45; i++) begin
         step(1'b0, 4'b0100);
         if (key_long[2]) begin nl++; lp = i; end
         if (key_repeat[2]) begin nr++; if (rp < 0) rp = i; end
      end
      check("hold_long_count", nl, 1);
      check("hold_long_pos", lp, 25);
      check("hold_repeat_count", nr, AR ? 2 : 0);
      check("hold_repeat_first", rp, AR ? 33 : -1);
      idle(10);

      // Release lands on the long cycle: release wins.
      nl = 0; nr = 0; nrel = 0; relp = -1;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, i < 20 ? 4'b0100 : 4'b0000);
         if (key_long[2]) nl++;
         if (key_repeat[2]) nr++;
         if (key_release[2]) begin nrel++; relp = i; end
      end
      check("race_long_count", nl, 0);
      check("race_repeat_count", nr, 0);
      check("race_release_count", nrel, 1);
      check("race_release_pos", relp, 25);
      idle(4);

      // Keys 0 and 3 together, 2-cycle glitch on key3 mid-hold.
      np = 0; nrel = 0; pv = '0; lv = '0;
      for (int i = 0; i < 35; i++) begin
         raw = 4'b1001;
         if (i == 10 || i == 11) raw[3] = 1'b0;
         step(1'b0, raw);
         if (key_press != 0) np++;
         if (key_release != 0) nrel++;
         if (i == 5) pv = key_press;
         if (i == 25) lv = key_long;
      end
      check("dual_press_vec", int'(pv), 'h9);
      check("dual_press_cycles", np, 1);
      check("glitch_release_count", nrel, 0);
      check("glitch_long_vec", int'(lv), 'h9);
      idle(10);

      // Reset mid-hold of key0; key still held afterwards gives a fresh press.
      for (int i = 0; i < 10; i++) step(1'b0, 4'b0001);
      step(1'b1, 4'b0001);
      check("rst_level", int'(key_level), 0);
      check("rst_press", int'(key_press), 0);
      check("rst_release", int'(key_release), 0);
      check("rst_long", int'(key_long), 0);
      check("rst_repeat", int'(key_repeat), 0);
      np = 0; pp = -1;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 4'b0001);
         if (key_press[0]) begin np++; pp = i; end
      end
      check("rst_repress_count", np, 1);
      check("rst_repress_pos", pp, 6);
      idle(10);

      // Random holds of mixed length, short glitches and rare resets.
      rnd_lvl = '0;
      for (int k = 0; k < N; k++) hold_left[k] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < N; k++) begin
            if (hold_left[k] == 0) begin
               rnd_lvl[k] = ~rnd_lvl[k];
               hold_left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 45));
            end
            hold_left[k]--;
         end
         step($urandom_range(0, 499) == 0, rnd_lvl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
